// File: rtl/fifo_ptr_pkg.sv
// Shared constants for the Hamming(14,10) protected FIFO pointer.
// Data bits are stored inverted so that pointer 0 is not an all-zero codeword.
package fifo_ptr_pkg;

    localparam int unsigned PTR_W = 10;
    localparam int unsigned ENC_W = 14;
    localparam int unsigned ERR_W = 4;
    localparam int unsigned PAR_N = 4;

    localparam logic [ENC_W-1:0] ENC_RST   = 14'h3F74;
    localparam logic [ERR_W-1:0] ERR_FATAL = 4'd15;

    // Codeword positions of pointer bits 0..9.
    localparam int unsigned DATA_POS [PTR_W] = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13};

    // Parity bit positions and the data bits each one covers (even parity).
    localparam int unsigned PAR_POS [PAR_N] = '{0, 1, 3, 7};
    localparam logic [ENC_W-1:0] PAR_MASK [PAR_N] = '{
        14'h1554,   // 2,4,6,8,10,12
        14'h2664,   // 2,5,6,9,10,13
        14'h3870,   // 4,5,6,11,12,13
        14'h3F00    // 8..13
    };

endpackage

// File: rtl/ptr_encode.sv
// Combinational pointer-to-codeword encoder: inverted data bits plus
// four even-parity bits.
module ptr_encode
    import fifo_ptr_pkg::*;
(
    input  logic [PTR_W-1:0] ptr,
    output logic [ENC_W-1:0] enc
);

    logic [ENC_W-1:0] data_c;

    always_comb begin
        data_c = '0;
        for (int i = 0; i < int'(PTR_W); i++) begin
            data_c[DATA_POS[i]] = ~ptr[i];
        end
        enc = data_c;
        for (int j = 0; j < int'(PAR_N); j++) begin
            enc[PAR_POS[j]] = ^(data_c & PAR_MASK[j]);
        end
    end

endmodule

// File: rtl/fifo_ptr_enc.sv
// Owns one FIFO pointer as a registered Hamming codeword: advance, clear,
// scrub on idle cycles, single-bit error injection and error bookkeeping.
module fifo_ptr_enc
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             scrub_en,
    input  logic [PTR_W-1:0] corr_ptr_in,
    input  logic [ERR_W-1:0] err_idx_in,
    input  logic             inj_vld,
    input  logic [ERR_W-1:0] inj_idx,
    output logic [ENC_W-1:0] enc_ptr,
    output logic             wrap,
    output logic             scrub_done,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fatal
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             err_corr_c;
    logic             scrub_c;
    logic             at_last_c;
    logic             inj_ok_c;
    logic             cnt_ev_c;
    logic             wrap_nxt_c;
    logic [PTR_W-1:0] enc_src_c;
    logic [ENC_W-1:0] enc_new_c;
    logic [ENC_W-1:0] base_c;
    logic [ENC_W-1:0] inj_mask_c;
    logic [ENC_W-1:0] enc_nxt_c;

    // Next-value selection; increments always start from the decoded pointer.
    always_comb begin
        err_corr_c = (err_idx_in != '0) && (err_idx_in != ERR_FATAL);
        scrub_c    = !clr && !inc && scrub_en && err_corr_c;
        at_last_c  = corr_ptr_in >= LAST_PTR;
        inj_ok_c   = inj_vld && !clr && (inj_idx != '0) && (inj_idx != ERR_FATAL);
        cnt_ev_c   = !clr && err_corr_c && (inc || scrub_en);

        enc_src_c  = corr_ptr_in;
        wrap_nxt_c = wrap;
        if (clr) begin
            enc_src_c  = '0;
            wrap_nxt_c = 1'b0;
        end else if (inc) begin
            enc_src_c  = at_last_c ? '0 : corr_ptr_in + PTR_W'(1);
            wrap_nxt_c = wrap ^ at_last_c;
        end

        base_c     = (clr || inc || scrub_c) ? enc_new_c : enc_ptr;
        inj_mask_c = inj_ok_c ? (ENC_W'(1) << (inj_idx - ERR_W'(1))) : '0;
        enc_nxt_c  = base_c ^ inj_mask_c;
    end

    ptr_encode u_encode (
        .ptr (enc_src_c),
        .enc (enc_new_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_ptr    <= ENC_RST;
            wrap       <= 1'b0;
            scrub_done <= 1'b0;
            err_cnt    <= '0;
            fatal      <= 1'b0;
        end else begin
            enc_ptr    <= enc_nxt_c;
            wrap       <= wrap_nxt_c;
            scrub_done <= scrub_c;
            if (cnt_ev_c && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (err_idx_in == ERR_FATAL) begin
                fatal <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_ptr_enc.sv
// Directed bench for fifo_ptr_enc with a behavioural Hamming decoder closing the loop.
module tb_fifo_ptr_enc;

    logic clk;
    logic rst_n;
    logic inc, clr, scrub_en, inj_vld, force_err;
    logic [3:0] inj_idx;
    logic inc10;

    logic [13:0] enc_ptr, enc10;
    logic        wrap, wrap10, scrub_done, sd10, fatal, fatal10;
    logic [7:0]  err_cnt, cnt10;
    logic [13:0] dec_m, dec_10;
    logic [9:0]  corr_m, corr_10;
    logic [3:0]  err_m, err_10;

    int n_cmp  = 0;
    int n_fail = 0;

    // Syndrome decoder: syndrome equals the 1-based position of a single flipped bit.
    function automatic logic [13:0] dec_fn(input logic [13:0] c);
        logic [3:0]  syn;
        logic [13:0] f;
        syn = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (c[i]) syn = syn ^ 4'(i + 1);
        end
        f = c;
        if (syn >= 4'd1 && syn <= 4'd14) f[syn - 4'd1] = ~f[syn - 4'd1];
        return {syn, ~{f[13], f[12], f[11], f[10], f[9], f[8], f[6], f[5], f[4], f[2]}};
    endfunction

    assign dec_m   = dec_fn(enc_ptr);
    assign corr_m  = dec_m[9:0];
    assign err_m   = force_err ? 4'd15 : dec_m[13:10];
    assign dec_10  = dec_fn(enc10);
    assign corr_10 = dec_10[9:0];
    assign err_10  = dec_10[13:10];

    fifo_ptr_enc #(.DEPTH(1024), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clr(clr), .scrub_en(scrub_en),
        .corr_ptr_in(corr_m), .err_idx_in(err_m), .inj_vld(inj_vld), .inj_idx(inj_idx),
        .enc_ptr(enc_ptr), .wrap(wrap), .scrub_done(scrub_done), .err_cnt(err_cnt), .fatal(fatal)
    );

    fifo_ptr_enc #(.DEPTH(10), .CNT_W(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .inc(inc10), .clr(1'b0), .scrub_en(1'b0),
        .corr_ptr_in(corr_10), .err_idx_in(err_10), .inj_vld(1'b0), .inj_idx(4'd0),
        .enc_ptr(enc10), .wrap(wrap10), .scrub_done(sd10), .err_cnt(cnt10), .fatal(fatal10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; inc = 0; clr = 0; scrub_en = 0; inj_vld = 0; inj_idx = 4'd0;
        force_err = 0; inc10 = 0;
        #12;
        check("rst_enc",   32'(enc_ptr), 32'h3F74);
        check("rst_wrap",  32'(wrap), 32'd0);
        check("rst_cnt",   32'(err_cnt), 32'd0);
        check("rst_fatal", 32'(fatal), 32'd0);
        check("rst_sd",    32'(scrub_done), 32'd0);
        check("rst_dec",   32'({err_m, corr_m}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Five advances through the decoder loop
        step();
        inc = 1;
        for (int k = 0; k < 5; k++) step();
        inc = 0;
        check("inc5_enc",  32'(enc_ptr), 32'h3F59);
        check("inc5_data", 32'(corr_m), 32'd5);
        check("inc5_err",  32'(err_m), 32'd0);

        // DEPTH=10 wrap
        inc10 = 1;
        for (int k = 0; k < 9; k++) step();
        check("d10_ptr9",  32'(corr_10), 32'd9);
        check("d10_wrap0", 32'(wrap10), 32'd0);
        step();
        inc10 = 0;
        check("d10_enc",   32'(enc10), 32'h3F74);
        check("d10_ptr0",  32'(corr_10), 32'd0);
        check("d10_wrap1", 32'(wrap10), 32'd1);

        // Clear, inject bit 6, then scrub it out
        clr = 1; step(); clr = 0;
        check("clr_enc",  32'(enc_ptr), 32'h3F74);
        check("clr_wrap", 32'(wrap), 32'd0);
        inj_vld = 1; inj_idx = 4'd7; step(); inj_vld = 0;
        check("inj_enc",  32'(enc_ptr), 32'h3F34);
        check("inj_err",  32'(err_m), 32'd7);
        check("inj_data", 32'(corr_m), 32'd0);
        check("inj_cnt",  32'(err_cnt), 32'd0);
        scrub_en = 1; step(); scrub_en = 0;
        check("scr_enc",  32'(enc_ptr), 32'h3F74);
        check("scr_sd1",  32'(scrub_done), 32'd1);
        check("scr_cnt",  32'(err_cnt), 32'd1);
        step();
        check("scr_sd0",  32'(scrub_done), 32'd0);

        // Inject then advance: corrected implicitly, counted, no scrub pulse
        inj_vld = 1; inj_idx = 4'd7; step(); inj_vld = 0;
        inc = 1; step(); inc = 0;
        check("incc_enc", 32'(enc_ptr), 32'h3F73);
        check("incc_cnt", 32'(err_cnt), 32'd2);
        check("incc_sd",  32'(scrub_done), 32'd0);
        // Out-of-range inj_idx is ignored
        inj_vld = 1; inj_idx = 4'd15; step(); inj_vld = 0;
        check("inj15_enc", 32'(enc_ptr), 32'h3F73);
        clr = 1; inc = 1; inj_vld = 1; inj_idx = 4'd3; step();
        clr = 0; inc = 0; inj_vld = 0;
        check("cii_enc",  32'(enc_ptr), 32'h3F74);
        check("cii_wrap", 32'(wrap), 32'd0);
        check("cii_cnt",  32'(err_cnt), 32'd2);

        // Uncorrectable indication: fatal sticky, no scrub, inc still advances
        force_err = 1; scrub_en = 1; step();
        check("fat_set",  32'(fatal), 32'd1);
        check("fat_enc",  32'(enc_ptr), 32'h3F74);
        check("fat_cnt",  32'(err_cnt), 32'd2);
        check("fat_sd",   32'(scrub_done), 32'd0);
        scrub_en = 0; inc = 1; step(); inc = 0;
        check("fat_inc",  32'(enc_ptr), 32'h3F73);
        force_err = 0; step();
        check("fat_stky", 32'(fatal), 32'd1);

        // Continuous inject+scrub saturates the counter
        scrub_en = 1; inj_vld = 1; inj_idx = 4'd1;
        for (int k = 0; k < 300; k++) step();
        check("sat_cnt",  32'(err_cnt), 32'hFF);
        scrub_en = 0; inj_vld = 0;

        // Asynchronous reset mid-operation
        inc = 1; inj_vld = 1; inj_idx = 4'd5; inc10 = 1;
        step();
        rst_n = 1'b0;
        #1;
        check("mrst_enc",   32'(enc_ptr), 32'h3F74);
        check("mrst_wrap",  32'(wrap), 32'd0);
        check("mrst_cnt",   32'(err_cnt), 32'd0);
        check("mrst_fatal", 32'(fatal), 32'd0);
        check("mrst_sd",    32'(scrub_done), 32'd0);
        check("mrst_enc10", 32'(enc10), 32'h3F74);
        @(posedge clk); #1;
        check("mrst_hold",  32'(enc_ptr), 32'h3F74);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
